// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the parametrised UART
//                transmitter (state encoding, width helper, limits).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Widest data field the transmitter is built to carry.
    localparam int UART_MAX_DATA_BITS = 9;

    // Transmitter frame states; PARITY is only reachable when parity is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Ceiling of log2, evaluated at elaboration time for counter widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick
//  Description : Restartable bit-period divider. Counts 0..CLK_DIV-1 and
//                pulses tick for one cycle at CLK_DIV-1. While clear is high
//                the count is held at zero so the first bit period is
//                measured from the acceptance edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_tick #(
    parameter int CLK_DIV = 5208
) (
    input  logic sysclk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] C_LAST = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: restart on clear, wrap at the end of a bit period.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clear || (cnt_q == C_LAST)) begin
            cnt_d = 16'd0;
        end
    end

    // Count register.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_param
//  Description : Parametrised UART transmitter with valid/ready input,
//                LSB-first data, 1 or 2 stop bits and an idle-high line.
//                Optional parity bit is built in when UART_TX_PARITY_EN is
//                defined; otherwise frames are start + data + stop.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 sysclk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 cereal,
    output logic                 busy
);

    localparam int             C_BW        = clog2(DATA_BITS);
    localparam logic [C_BW-1:0] C_LAST_DATA = C_BW'(DATA_BITS - 1);
    localparam logic [C_BW-1:0] C_LAST_STOP = C_BW'(STOP_BITS - 1);

    uart_tx_state_t        state_q,    state_d;
    logic [DATA_BITS-1:0]  shift_q,    shift_d;
    logic [C_BW-1:0]       bit_cnt_q,  bit_cnt_d;
    logic                  cereal_q,   cereal_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  busy_q,     busy_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q,   parity_d;
`endif

    logic w_tick;
    logic w_accept;
    logic w_baud_clear;

    // Divider is held at zero while idle so timing restarts on acceptance.
    assign w_baud_clear = (state_q == IDLE);
    assign w_accept     = tx_valid & tx_ready_q;

    baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .sysclk (sysclk),
        .rst    (rst),
        .clear  (w_baud_clear),
        .tick   (w_tick)
    );

    // Frame sequencing, shift register and bit counter next-state logic.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    shift_d   = tx_data;
                    bit_cnt_d = '0;
                    state_d   = START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = (^tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (w_tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == C_LAST_DATA) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    if (bit_cnt_q == C_LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Output levels are derived from the next state so they register together with it.
    always_comb begin
        cereal_d = 1'b1;
        case (state_d)
            START:   cereal_d = 1'b0;
            DATA:    cereal_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  cereal_d = parity_d;
`endif
            default: cereal_d = 1'b1;
        endcase
        tx_ready_d = (state_d == IDLE);
        busy_d     = ~tx_ready_d;
    end

    // State and registered outputs.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            cereal_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            cereal_q   <= cereal_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign cereal   = cereal_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_param
//  Description : Self-checking bench for uart_tx_param. Four instances cover
//                8N1 at CLK_DIV=4, 7-bit/2-stop with even and odd parity
//                settings, and the default 5208 divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
    localparam int PBIT = 1;
`else
    localparam int PBIT = 0;
`endif

    logic       sysclk = 1'b0;
    logic       rst    = 1'b1;
    logic       tx_valid [4];
    logic [8:0] tx_data  [4];
    logic       cereal   [4];
    logic       tx_ready [4];
    logic       busy     [4];

    int   total = 0;
    int   bad   = 0;
    logic exp_q [$];

    always #5 sysclk = ~sysclk;

    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
        .sysclk(sysclk), .rst(rst), .tx_data(tx_data[0][7:0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .cereal(cereal[0]), .busy(busy[0]));
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u_dut1 (
        .sysclk(sysclk), .rst(rst), .tx_data(tx_data[1][6:0]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .cereal(cereal[1]), .busy(busy[1]));
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) u_dut2 (
        .sysclk(sysclk), .rst(rst), .tx_data(tx_data[2][6:0]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .cereal(cereal[2]), .busy(busy[2]));
    uart_tx_param #(.CLK_DIV(5208), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut3 (
        .sysclk(sysclk), .rst(rst), .tx_data(tx_data[3][7:0]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .cereal(cereal[3]), .busy(busy[3]));

    function automatic int div_of(input int k);
        return (k == 3) ? 5208 : 4;
    endfunction
    function automatic int db_of(input int k);
        return (k == 1 || k == 2) ? 7 : 8;
    endfunction
    function automatic int sb_of(input int k);
        return (k == 1 || k == 2) ? 2 : 1;
    endfunction
    function automatic logic po_of(input int k);
        return (k == 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Scoreboard: queue the line levels a frame of d must produce on instance k.
    task automatic push_frame(input int k, input logic [8:0] d);
        logic p;
        p = po_of(k);
        exp_q.push_back(1'b0);
        for (int i = 0; i < db_of(k); i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (PBIT == 1) exp_q.push_back(p);
        for (int i = 0; i < sb_of(k); i++) exp_q.push_back(1'b1);
    endtask

    // Present d for one cycle; returns 1 ns after the acceptance edge.
    task automatic send(input int k, input logic [8:0] d, input bit hold);
        chk("ready_before_send", 32'(tx_ready[k]), 32'd1);
        tx_data[k]  = d;
        tx_valid[k] = 1'b1;
        push_frame(k, d);
        step(1);
        if (!hold) tx_valid[k] = 1'b0;
    endtask

    // Walk one frame from cycle 0 after acceptance; check first and last cycle of every bit.
    task automatic check_line(input int k, input string tag, input bit disturb);
        int   div;
        int   n;
        logic e;
        div = div_of(k);
        n   = 1 + db_of(k) + PBIT + sb_of(k);
        chk({tag, "_busy"},  32'(busy[k]),     32'd1);
        chk({tag, "_ready"}, 32'(tx_ready[k]), 32'd0);
        for (int b = 0; b < n; b++) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
                e = 1'b1;
            end else begin
                e = exp_q.pop_front();
            end
            chk($sformatf("%s_bit%0d_first", tag, b), 32'(cereal[k]), 32'(e));
            if (disturb) begin
                if (b < n - 1) begin
                    tx_valid[k] = 1'($urandom_range(0, 1));
                    tx_data[k]  = 9'($urandom);
                end else begin
                    tx_valid[k] = 1'b0;
                end
            end
            step(div - 1);
            chk($sformatf("%s_bit%0d_last", tag, b), 32'(cereal[k]), 32'(e));
            chk($sformatf("%s_bit%0d_ready", tag, b), 32'(tx_ready[k]), 32'd0);
            step(1);
        end
        chk({tag, "_end_ready"},  32'(tx_ready[k]), 32'd1);
        chk({tag, "_end_busy"},   32'(busy[k]),     32'd0);
        chk({tag, "_end_line"},   32'(cereal[k]),   32'd1);
    endtask

    initial begin
        logic activity;
        for (int k = 0; k < 4; k++) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = 9'd0;
        end

        // Reset held for three edges.
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_line%0d", k),  32'(cereal[k]),   32'd1);
            chk($sformatf("reset_ready%0d", k), 32'(tx_ready[k]), 32'd1);
            chk($sformatf("reset_busy%0d", k),  32'(busy[k]),     32'd0);
        end
        activity = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step(1);
            for (int k = 0; k < 4; k++) if (cereal[k] !== 1'b1 || tx_ready[k] !== 1'b1) activity = 1'b1;
        end
        chk("idle_quiet", 32'(activity), 32'd0);

        // 8N1 frame of 0xA5.
        send(0, 9'h0A5, 1'b0);
        check_line(0, "frame_a5", 1'b0);

        // 7-bit, 2 stop bits, even then odd parity setting.
        step(2);
        send(1, 9'h003, 1'b0);
        check_line(1, "even_03", 1'b0);
        step(2);
        send(2, 9'h007, 1'b0);
        check_line(2, "odd_07", 1'b0);

        // Back-to-back with tx_valid held high.
        step(2);
        send(0, 9'h000, 1'b1);
        tx_data[0] = 9'h0FF;
        push_frame(0, 9'h0FF);
        check_line(0, "b2b_first", 1'b0);
        step(1);
        tx_valid[0] = 1'b0;
        check_line(0, "b2b_second", 1'b0);

        // Reset pulse during data bit 3, then a clean frame under input noise.
        step(2);
        send(0, 9'h0A5, 1'b0);
        step(4 * 4 + 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_line",  32'(cereal[0]),   32'd1);
        chk("midrst_ready", 32'(tx_ready[0]), 32'd1);
        chk("midrst_busy",  32'(busy[0]),     32'd0);
        exp_q.delete();
        step(3);
        chk("midrst_stays_idle", 32'(cereal[0]), 32'd1);
        send(0, 9'h055, 1'b0);
        check_line(0, "after_rst_55", 1'b1);

        // Default divider.
        step(2);
        send(3, 9'h041, 1'b0);
        check_line(3, "div5208_41", 1'b0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
